// File: rtl/exe_stage.sv
// Execute stage: operand select, ALU, HI/LO (multiply, optional divide) and data-SRAM request.
// Define EXE_DIV_EN to build the 32-cycle restoring divider; otherwise div/divu leave HI/LO alone.

module alu (
   input  logic [11:0] alu_op,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);
   logic [31:0] add_r, sub_r, slt_r, sltu_r, sll_r, srl_r, sra_r, lui_r;

   always_comb begin
      add_r  = alu_src1 + alu_src2;
      sub_r  = alu_src1 - alu_src2;
      slt_r  = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      sltu_r = {31'd0, alu_src1 < alu_src2};
      sll_r  = alu_src2 << alu_src1[4:0];
      srl_r  = alu_src2 >> alu_src1[4:0];
      sra_r  = 32'($signed(alu_src2) >>> alu_src1[4:0]);
      lui_r  = {alu_src2[15:0], 16'd0};
      alu_result = ({32{alu_op[0]}}  & add_r)
                 | ({32{alu_op[1]}}  & sub_r)
                 | ({32{alu_op[2]}}  & slt_r)
                 | ({32{alu_op[3]}}  & sltu_r)
                 | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                 | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                 | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                 | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                 | ({32{alu_op[8]}}  & sll_r)
                 | ({32{alu_op[9]}}  & srl_r)
                 | ({32{alu_op[10]}} & sra_r)
                 | ({32{alu_op[11]}} & lui_r);
   end
endmodule

module exe_stage #(
   localparam int unsigned DS_TO_ES_BUS_WD = 142,
   localparam int unsigned ES_TO_MS_BUS_WD = 71
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ms_allowin,
   output logic                       es_allowin,
   input  logic                       ds_to_es_valid,
   input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                       es_to_ms_valid,
   output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       data_sram_en,
   output logic [3:0]                 data_sram_wen,
   output logic [31:0]                data_sram_addr,
   output logic [31:0]                data_sram_wdata
);
   logic                       es_valid;
   logic [DS_TO_ES_BUS_WD-1:0] es_r;
   logic                       es_ready_go;
   logic                       hs;

   logic        es_mult, es_multu, es_div, es_divu, es_mfhi, es_mflo;
   logic [11:0] es_alu_op;
   logic        es_load_op, es_src1_is_sa, es_src1_is_pc, es_src2_is_imm, es_src2_is_8;
   logic        es_gr_we, es_mem_we;
   logic [4:0]  es_dest;
   logic [15:0] es_imm;
   logic [31:0] es_rs_value, es_rt_value, es_pc;

   assign {es_mult, es_multu, es_div, es_divu, es_mfhi, es_mflo,
           es_alu_op,
           es_load_op, es_src1_is_sa, es_src1_is_pc, es_src2_is_imm, es_src2_is_8,
           es_gr_we, es_mem_we,
           es_dest, es_imm, es_rs_value, es_rt_value, es_pc} = es_r;

   logic [31:0] src1, src2, alu_out, alu_result;
   logic [31:0] hi, lo;
   logic [63:0] prod;

   assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
   assign hs             = es_valid && es_ready_go && ms_allowin;
   assign es_to_ms_valid = es_valid && es_ready_go;

   always_ff @(posedge clk) begin
      if (reset)           es_valid <= 1'b0;
      else if (es_allowin) es_valid <= ds_to_es_valid;
   end

   always_ff @(posedge clk) begin
      if (reset)                              es_r <= '0;
      else if (ds_to_es_valid && es_allowin) es_r <= ds_to_es_bus;
   end

   always_comb begin
      src1 = es_src1_is_sa ? {27'd0, es_imm[10:6]} :
             es_src1_is_pc ? es_pc : es_rs_value;
      src2 = es_src2_is_imm ? {{16{es_imm[15]}}, es_imm} :
             es_src2_is_8   ? 32'd8 : es_rt_value;
   end

   alu u_alu (
      .alu_op    (es_alu_op),
      .alu_src1  (src1),
      .alu_src2  (src2),
      .alu_result(alu_out)
   );

   // Both operands widened to 64 bits so one multiplier serves mult and multu.
   always_comb begin
      if (es_mult)
         prod = 64'($signed({{32{es_rs_value[31]}}, es_rs_value}) *
                    $signed({{32{es_rt_value[31]}}, es_rt_value}));
      else
         prod = 64'({32'd0, es_rs_value} * {32'd0, es_rt_value});
   end

`ifdef EXE_DIV_EN
   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

   div_state_t  div_state;
   logic [4:0]  div_cnt;
   logic [31:0] div_rem, div_quo, div_dvs;
   logic        div_q_neg, div_r_neg;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, rem_next, quo_next, rem_fix, quo_fix;
   logic [32:0] div_shift, div_diff;
   logic        div_ge;

   always_comb begin
      a_neg     = es_div && es_rs_value[31];
      b_neg     = es_div && es_rt_value[31];
      a_mag     = a_neg ? (~es_rs_value + 32'd1) : es_rs_value;
      b_mag     = b_neg ? (~es_rt_value + 32'd1) : es_rt_value;
      div_shift = {div_rem, div_quo[31]};
      div_diff  = div_shift - {1'b0, div_dvs};
      div_ge    = div_shift >= {1'b0, div_dvs};
      rem_next  = div_ge ? 32'(div_diff) : 32'(div_shift);
      quo_next  = {div_quo[30:0], div_ge};
      quo_fix   = div_q_neg ? (~div_quo + 32'd1) : div_quo;
      rem_fix   = div_r_neg ? (~div_rem + 32'd1) : div_rem;
   end

   // Divisor zero falls out naturally: every trial succeeds, quotient all ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_state <= DIV_IDLE;
         div_cnt   <= '0;
         div_rem   <= '0;
         div_quo   <= '0;
         div_dvs   <= '0;
         div_q_neg <= 1'b0;
         div_r_neg <= 1'b0;
      end else begin
         case (div_state)
            DIV_IDLE: if (es_valid && (es_div || es_divu)) begin
               div_state <= DIV_BUSY;
               div_cnt   <= '0;
               div_rem   <= '0;
               div_quo   <= a_mag;
               div_dvs   <= b_mag;
               div_q_neg <= a_neg ^ b_neg;
               div_r_neg <= a_neg;
            end
            DIV_BUSY: begin
               div_rem <= rem_next;
               div_quo <= quo_next;
               div_cnt <= div_cnt + 5'd1;
               if (div_cnt == 5'd31) div_state <= DIV_DONE;
            end
            DIV_DONE: if (hs) div_state <= DIV_IDLE;
            default:  div_state <= DIV_IDLE;
         endcase
      end
   end

   assign es_ready_go = !(es_div || es_divu) || (div_state == DIV_DONE);
`else
   logic unused_div_bits;
   assign unused_div_bits = es_div ^ es_divu;
   assign es_ready_go     = 1'b1;
`endif

   // HI/LO change only on the handshake edge, so the next mfhi/mflo sees them.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (hs && (es_mult || es_multu)) begin
         {hi, lo} <= prod;
      end
`ifdef EXE_DIV_EN
      else if (hs && (es_div || es_divu)) begin
         hi <= rem_fix;
         lo <= quo_fix;
      end
`endif
   end

   assign alu_result = es_mfhi ? hi : es_mflo ? lo : alu_out;

   assign es_to_ms_bus = es_to_ms_valid ?
                         {es_load_op, es_gr_we, es_dest, alu_result, es_pc} : '0;

   assign data_sram_en    = hs && (es_load_op || es_mem_we);
   assign data_sram_wen   = {4{data_sram_en && es_mem_we}};
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = es_rt_value;
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage; expected execute-bus words flow through a scoreboard queue.

module tb_exe_stage;
   logic         clk = 1'b0;
   logic         reset;
   logic         ms_allowin;
   logic         es_allowin;
   logic         ds_to_es_valid;
   logic [141:0] ds_to_es_bus;
   logic         es_to_ms_valid;
   logic [70:0]  es_to_ms_bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;

   int checks = 0;
   int failures = 0;
   logic [70:0] exp_q[$];

   always #5 clk = ~clk;

   exe_stage dut (
      .clk            (clk),
      .reset          (reset),
      .ms_allowin     (ms_allowin),
      .es_allowin     (es_allowin),
      .ds_to_es_valid (ds_to_es_valid),
      .ds_to_es_bus   (ds_to_es_bus),
      .es_to_ms_valid (es_to_ms_valid),
      .es_to_ms_bus   (es_to_ms_bus),
      .data_sram_en   (data_sram_en),
      .data_sram_wen  (data_sram_wen),
      .data_sram_addr (data_sram_addr),
      .data_sram_wdata(data_sram_wdata)
   );

   // md = {mult, multu, div, divu, mfhi, mflo}; ctl = {load_op, sa, pc, imm, 8, gr_we, mem_we}
   function automatic logic [141:0] mk(input logic [5:0] md, input logic [11:0] op,
                                       input logic [6:0] ctl, input logic [4:0] dest,
                                       input logic [15:0] imm, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [31:0] pc);
      return {md, op, ctl, dest, imm, rs, rt, pc};
   endfunction

   task automatic issue_div(input logic [5:0] md, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, output int rise);
      @(negedge clk);
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(md, 12'h000, 7'b0, 5'd0, 16'h0, a, b, pc);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      rise = -1;
      for (int k = 0; k < 60; k++) begin
         #1;
         if (es_to_ms_valid) begin
            rise = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi_v, output logic [31:0] lo_v);
      @(negedge clk);
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(6'b000010, 12'h000, 7'b0000010, 5'd2, 16'h0, 32'd0, 32'd0, 32'h400);
      @(negedge clk);
      ds_to_es_bus   = mk(6'b000001, 12'h000, 7'b0000010, 5'd3, 16'h0, 32'd0, 32'd0, 32'h404);
      #1 hi_v = es_to_ms_bus[63:32];
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      #1 lo_v = es_to_ms_bus[63:32];
   endtask

   task automatic test_reset();
      reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", es_to_ms_valid); end
      checks++; if (es_to_ms_bus !== 71'd0) begin failures++; $display("FAIL reset_bus got=%h exp=0", es_to_ms_bus); end
      checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", data_sram_en); end
      checks++; if (data_sram_wen !== 4'h0) begin failures++; $display("FAIL reset_wen got=%h exp=0", data_sram_wen); end
      checks++; if (es_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", es_allowin); end
   endtask

   task automatic test_addiu();
      logic [70:0] e;
      @(negedge clk);
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(6'b0, 12'h001, 7'b0001010, 5'd9, 16'hFFFF, 32'd5, 32'd0, 32'hBFC00010);
      exp_q.push_back({1'b0, 1'b1, 5'd9, 32'd4, 32'hBFC00010});
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      #1;
      checks++; if (es_to_ms_valid !== 1'b1) begin failures++; $display("FAIL addiu_valid got=%b exp=1", es_to_ms_valid); end
      e = exp_q.pop_front();
      checks++; if (es_to_ms_bus !== e) begin failures++; $display("FAIL addiu_bus got=%h exp=%h", es_to_ms_bus, e); end
      checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL addiu_en got=%b exp=0", data_sram_en); end
      @(negedge clk); #1;
      checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL addiu_drain got=%b exp=0", es_to_ms_valid); end
   endtask

   task automatic test_sw();
      logic [70:0] e;
      @(negedge clk);
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(6'b0, 12'h001, 7'b0001001, 5'd0, 16'h0008, 32'h100, 32'hDEADBEEF, 32'hBFC00020);
      exp_q.push_back({1'b0, 1'b0, 5'd0, 32'h108, 32'hBFC00020});
      #1;
      checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL sw_pre_en got=%b exp=0", data_sram_en); end
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      #1;
      checks++; if (data_sram_en !== 1'b1) begin failures++; $display("FAIL sw_en got=%b exp=1", data_sram_en); end
      checks++; if (data_sram_wen !== 4'hF) begin failures++; $display("FAIL sw_wen got=%h exp=f", data_sram_wen); end
      checks++; if (data_sram_addr !== 32'h108) begin failures++; $display("FAIL sw_addr got=%h exp=108", data_sram_addr); end
      checks++; if (data_sram_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", data_sram_wdata); end
      e = exp_q.pop_front();
      checks++; if (es_to_ms_bus !== e) begin failures++; $display("FAIL sw_bus got=%h exp=%h", es_to_ms_bus, e); end
      @(negedge clk); #1;
      checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL sw_post_en got=%b exp=0", data_sram_en); end
   endtask

   task automatic test_lw_stall();
      logic [70:0] e;
      int pulses = 0;
      @(negedge clk);
      ms_allowin     = 1'b0;
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(6'b0, 12'h001, 7'b1001010, 5'd7, 16'h0004, 32'd200, 32'd0, 32'hBFC00030);
      exp_q.push_back({1'b1, 1'b1, 5'd7, 32'd204, 32'hBFC00030});
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         ds_to_es_valid = 1'b0;
         ms_allowin     = (k >= 3);
         #1;
         if (data_sram_en) pulses++;
         checks++;
         if (data_sram_en !== (k == 3)) begin
            failures++; $display("FAIL lw_en_cycle%0d got=%b exp=%b", k, data_sram_en, (k == 3));
         end
         if (k == 3) begin
            e = exp_q.pop_front();
            checks++; if (es_to_ms_bus !== e) begin failures++; $display("FAIL lw_bus got=%h exp=%h", es_to_ms_bus, e); end
            checks++; if (data_sram_wen !== 4'h0) begin failures++; $display("FAIL lw_wen got=%h exp=0", data_sram_wen); end
         end
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL lw_pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_mult_back_to_back();
      logic [141:0] ins[3];
      logic [70:0]  ex[3];
      logic [70:0]  e;
      ins[0] = mk(6'b100000, 12'h000, 7'b0000000, 5'd0, 16'h0, 32'hFFFFFFFD, 32'd7, 32'h200);
      ins[1] = mk(6'b000010, 12'h000, 7'b0000010, 5'd8, 16'h0, 32'd0, 32'd0, 32'h204);
      ins[2] = mk(6'b000001, 12'h000, 7'b0000010, 5'd9, 16'h0, 32'd0, 32'd0, 32'h208);
      ex[0]  = {1'b0, 1'b0, 5'd0, 32'd0, 32'h200};
      ex[1]  = {1'b0, 1'b1, 5'd8, 32'hFFFFFFFF, 32'h204};
      ex[2]  = {1'b0, 1'b1, 5'd9, 32'hFFFFFFEB, 32'h208};
      ms_allowin = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) begin
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = ins[k];
            exp_q.push_back(ex[k]);
         end else begin
            ds_to_es_valid = 1'b0;
         end
         #1;
         if (k > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (!es_to_ms_valid || es_to_ms_bus !== e) begin
               failures++; $display("FAIL mult_seq%0d valid=%b got=%h exp=%h", k - 1, es_to_ms_valid, es_to_ms_bus, e);
            end
         end
      end
   endtask

   task automatic test_alu_stream();
      logic [11:0] t_op[12];
      logic [6:0]  t_ctl[12];
      logic [15:0] t_imm[12];
      logic [31:0] t_rs[12], t_rt[12], t_exp[12];
      logic [31:0] pc, res;
      logic [70:0] e;
      int i = 0;
      int cyc = 0;
      t_op  = '{12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040, 12'h080,
                12'h100, 12'h200, 12'h400, 12'h800, 12'h001};
      t_ctl = '{7'b0000010, 7'b0000010, 7'b0000010, 7'b0000010, 7'b0000010, 7'b0000010,
                7'b0000010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0001010, 7'b0010110};
      t_imm = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                16'h0100, 16'h0100, 16'h0100, 16'h1234, 16'h0};
      t_rs  = '{32'h80000010, 32'h80000010, 32'h80000010, 32'h80000010, 32'h80000010,
                32'h80000010, 32'h80000010, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      t_rt  = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3,
                32'd3, 32'h80000000, 32'h80000000, 32'd0, 32'd0};
      t_exp = '{32'h8000000D, 32'd1, 32'd0, 32'd0, 32'h7FFFFFEC, 32'h80000013, 32'h80000013,
                32'h30, 32'h08000000, 32'hF8000000, 32'h12340000, 32'd0};
      while ((i < 12 || exp_q.size() != 0) && cyc < 300) begin
         @(negedge clk);
         cyc++;
         ms_allowin = ($urandom_range(0, 3) != 0);
         pc = 32'hBFC00100 + 32'(i) * 32'd4;
         if (i < 12) begin
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = mk(6'b0, t_op[i], t_ctl[i], 5'(i + 1), t_imm[i], t_rs[i], t_rt[i], pc);
         end else begin
            ds_to_es_valid = 1'b0;
         end
         #1;
         if (es_to_ms_valid && ms_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL alu_unexpected got=%h exp=none", es_to_ms_bus);
            end else begin
               e = exp_q.pop_front();
               if (es_to_ms_bus !== e) begin
                  failures++; $display("FAIL alu_stream got=%h exp=%h", es_to_ms_bus, e);
               end
            end
         end
         if (ds_to_es_valid && es_allowin) begin
            res = (i == 11) ? pc + 32'd8 : t_exp[i];
            exp_q.push_back({1'b0, 1'b1, 5'(i + 1), res, pc});
            i++;
         end
      end
      checks++;
      if (i < 12 || exp_q.size() != 0) begin
         failures++; $display("FAIL alu_timeout issued=%0d pending=%0d exp=12/0", i, exp_q.size());
      end
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      ms_allowin     = 1'b1;
      exp_q.delete();
   endtask

`ifdef EXE_DIV_EN
   task automatic test_div();
      int rise;
      logic [31:0] h, l;
      logic [70:0] e;
      issue_div(6'b001000, 32'hFFFFFFF9, 32'd2, 32'h300, rise);
      exp_q.push_back({1'b0, 1'b0, 5'd0, 32'd0, 32'h300});
      checks++; if (rise != 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", rise); end
      e = exp_q.pop_front();
      checks++; if (es_to_ms_bus !== e) begin failures++; $display("FAIL div_bus got=%h exp=%h", es_to_ms_bus, e); end
      read_hilo(h, l);
      checks++; if (l !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", l); end
      checks++; if (h !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", h); end
      issue_div(6'b000100, 32'd7, 32'd0, 32'h310, rise);
      checks++; if (rise != 33) begin failures++; $display("FAIL divu0_latency got=%0d exp=33", rise); end
      read_hilo(h, l);
      checks++; if (l !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0_lo got=%h exp=ffffffff", l); end
      checks++; if (h !== 32'd7) begin failures++; $display("FAIL divu0_hi got=%h exp=7", h); end
   endtask

   task automatic test_reset_busy();
      int rise;
      logic [31:0] h, l;
      @(negedge clk);
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(6'b000100, 12'h000, 7'b0, 5'd0, 16'h0, 32'd50, 32'd3, 32'h320);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (es_to_ms_valid !== 1'b0) begin failures++; $display("FAIL rstbusy_valid got=%b exp=0", es_to_ms_valid); end
      checks++; if (es_allowin !== 1'b1) begin failures++; $display("FAIL rstbusy_allowin got=%b exp=1", es_allowin); end
      issue_div(6'b000100, 32'd100, 32'd7, 32'h330, rise);
      checks++; if (rise != 33) begin failures++; $display("FAIL rstbusy_latency got=%0d exp=33", rise); end
      read_hilo(h, l);
      checks++; if (l !== 32'd14) begin failures++; $display("FAIL rstbusy_lo got=%h exp=e", l); end
      checks++; if (h !== 32'd2) begin failures++; $display("FAIL rstbusy_hi got=%h exp=2", h); end
   endtask
`else
   task automatic test_div_disabled();
      int rise;
      logic [31:0] h, l;
      issue_div(6'b001000, 32'd7, 32'd2, 32'h300, rise);
      checks++; if (rise != 0) begin failures++; $display("FAIL nodiv_latency got=%0d exp=0", rise); end
      read_hilo(h, l);
      checks++; if (l !== 32'hFFFFFFEB) begin failures++; $display("FAIL nodiv_lo got=%h exp=ffffffeb", l); end
      checks++; if (h !== 32'hFFFFFFFF) begin failures++; $display("FAIL nodiv_hi got=%h exp=ffffffff", h); end
   endtask
`endif

   initial begin
      test_reset();
      test_addiu();
      test_sw();
      test_lw_stall();
      test_mult_back_to_back();
      test_alu_stream();
`ifdef EXE_DIV_EN
      test_div();
      test_reset_busy();
`else
      test_div_disabled();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
